lcd_16207_sequencer: RTL and testbench
======================================

Name: lcd_16207_sequencer

Overview:
- Timing-correct bus master for the 16207 (HD44780-compatible) character LCD.
- Runs the 8-bit power-on init sequence itself, then accepts commands from a simple valid/ready command port.
- Before each user access, it polls the busy flag (D7), then generates the setup, E-pulse, hold and cycle-time windows in clock cycles.
- Replaces direct bus-driven LCD access, where E simply tracked read/write strobes, for software that cannot guarantee LCD timing.

Parameters:
- T_AS, 8, RS/RW setup cycles before E rises.
- T_PW, 24, E high cycles.
- T_H, 4, cycles after E falls during which RS/RW/data are held.
- T_CYCLE, 60, minimum cycles from one E rise to the next (must be ≥ T_AS+T_PW+T_H).
- POWERUP, 750000, wait after reset before the first init write (15 ms @ 50 MHz).
- INIT_GAP, 205000, wait after the first 0x38 (4.1 ms).
- INIT_GAP_SHORT, 5000, wait after the second 0x38 (100 us).
- BUSY_TIMEOUT, 100000, maximum poll cycles per command before giving up.
- CW, 20, width of the delay counter; must hold the largest parameter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_rs  in  1  LCD register select for the command
- cmd_rw  in  1  1 = read access, 0 = write access
- cmd_data  in  8  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse: read data available
- rsp_data  out  8  read data, held until the next read
- init_done  out  1  high once the init sequence has completed
- busy_timeout  out  1  sticky flag: a busy poll expired
- LCD_E  out  1  LCD enable
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  LCD read/write
- LCD_data  inout  8  LCD data bus

Behaviour:
- Clock and reset: single clock domain on clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_data released (Z), cmd_ready=0, rsp_valid=0, rsp_data=0, init_done=0, busy_timeout=0.
- Reset mid-operation: reset aborts any access. E falls on the next edge and init restarts from PWR_WAIT.
- Bus cycle engine states: SETUP (T_AS cycles, E=0, RS/RW driven) -> PULSE (T_PW cycles, E=1) -> HOLD (T_H cycles, E=0) -> RECOVER (pads so the next E rise is ≥ T_CYCLE after this one).
  - Write (RW=0): LCD_data is driven from the first SETUP cycle through the last HOLD cycle and released otherwise.
  - Read (RW=1): the bus is never driven. LCD_data is sampled on the last PULSE cycle.
- Idle bus state: E=0, RW=1, RS=0, bus Z.
- Top FSM: PWR_WAIT -> F1 -> GAP1 -> F2 -> GAP2 -> F3 -> INIT_CMDS -> IDLE, with POLL -> EXEC for user commands.
  - PWR_WAIT counts POWERUP cycles.
  - F1, F2 and F3 each write RS=0, data 0x38 without busy polling. GAP1 waits INIT_GAP; GAP2 waits INIT_GAP_SHORT.
  - INIT_CMDS writes 0x38, 0x0C, 0x01, 0x06 (RS=0), each preceded by a busy poll.
  - init_done rises the cycle IDLE is first entered and stays high until reset.
- Busy poll: repeated read cycles with RS=0, RW=1 until sampled D7=0, then the pending access runs. Poll reads never produce rsp_valid.
  - A poll-cycle counter starts at POLL entry. If it reaches BUSY_TIMEOUT, busy_timeout is set (sticky) and the pending access proceeds anyway.
- Command handshake:
  - cmd_ready=1 only in IDLE with init_done=1.
  - Transfer occurs on a cycle with cmd_valid & cmd_ready. cmd_rs, cmd_rw and cmd_data are captured, and cmd_ready is 0 from the next cycle until IDLE is re-entered.
  - No command is accepted during init. cmd_valid held during init is accepted on the first IDLE cycle.
  - Every user access (read or write) is preceded by a busy poll.
- Read completion: for a user read, rsp_data is updated and rsp_valid pulses for 1 cycle at the end of HOLD.
- Back-to-back commands: T_CYCLE spacing between consecutive E rises is maintained across command boundaries, including poll-to-exec.

Test Plan:
All scenarios use T_AS=2, T_PW=3, T_H=1, T_CYCLE=10, POWERUP=50, INIT_GAP=20, INIT_GAP_SHORT=5, BUSY_TIMEOUT=40, with an LCD model that returns D7=0 unless stated.
- Init: release reset -> no E rise before cycle 50. Write data sequence is 38,38,38,38,0C,01,06 with RS=0. Gaps ≥20 and ≥5 after the first and second writes. init_done=1 after the last write; cmd_ready=1 the same cycle.
- Write: cmd RS=1 RW=0 data 0x41 -> one poll read, then a write. E high exactly 3 cycles. LCD_data=0x41 stable from SETUP through HOLD. RS/RW stable ≥2 cycles before E rise. E rises ≥10 cycles apart.
- Busy wait: model returns D7=1 for the first 3 polls -> 4 poll reads, then the write. busy_timeout stays 0.
- Timeout: D7 stuck at 1 -> busy_timeout=1 within 40+T_CYCLE cycles of POLL entry. The write is still performed and the flag persists across later commands until reset.
- Read: cmd RS=1 RW=1, model drives 0x5A -> rsp_valid pulses once with rsp_data=0x5A. The controller never drives LCD_data.
- Reset mid-pulse: assert reset while E=1 -> E=0 and bus Z next cycle, cmd_ready=0, init_done=0. The full init sequence is repeated.

Source files
------------

// File: rtl/lcd_16207_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_16207_sequencer
// Description : Timing-correct bus master for a 16207 / HD44780-compatible
//               character LCD. Runs the 8-bit power-on init sequence, then
//               serves a valid/ready command port. Every busy-polled access
//               reads D7 until clear, then runs SETUP/PULSE/HOLD/RECOVER
//               windows counted in clk cycles.
// Ports       : clk, reset (sync, active-high)
//               cmd_valid/cmd_ready/cmd_rs/cmd_rw/cmd_data - command port
//               rsp_valid/rsp_data  - read response (1-cycle pulse, held data)
//               init_done, busy_timeout (sticky)
//               LCD_E, LCD_RS, LCD_RW, LCD_data (inout) - LCD bus
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_16207_sequencer #(
    parameter int T_AS           = 8,
    parameter int T_PW           = 24,
    parameter int T_H            = 4,
    parameter int T_CYCLE        = 60,
    parameter int POWERUP        = 750000,
    parameter int INIT_GAP       = 205000,
    parameter int INIT_GAP_SHORT = 5000,
    parameter int BUSY_TIMEOUT   = 100000,
    parameter int CW             = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       init_done,
    output logic       busy_timeout,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam logic [CW-1:0] c_one       = CW'(1);
    localparam logic [CW-1:0] c_as_last   = CW'(T_AS - 1);
    localparam logic [CW-1:0] c_pw_last   = CW'(T_PW - 1);
    localparam logic [CW-1:0] c_h_last    = CW'(T_H - 1);
    // RECOVER exits once this many cycles have passed since E rose; the
    // one IDLE cycle plus T_AS of SETUP then land the next rise at T_CYCLE.
    localparam logic [CW-1:0] c_rec       = CW'(T_CYCLE - T_AS - 1);
    localparam logic [CW-1:0] c_cyc       = CW'(T_CYCLE);
    localparam logic [CW-1:0] c_pwr_last  = CW'(POWERUP - 1);
    localparam logic [CW-1:0] c_gap1_last = CW'(INIT_GAP - 1);
    localparam logic [CW-1:0] c_gap2_last = CW'(INIT_GAP_SHORT - 1);
    localparam logic [CW-1:0] c_bto       = CW'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD, PH_RECOVER
    } ph_t;

    typedef enum logic [3:0] {
        ST_PWR_WAIT, ST_F1, ST_GAP1, ST_F2, ST_GAP2, ST_F3,
        ST_INIT_CMDS, ST_IDLE, ST_POLL, ST_EXEC
    } st_t;

    st_t           r_st, w_st_nx;
    ph_t           r_ph, w_ph_nx;
    logic [CW-1:0] r_bcnt, w_bcnt_nx;
    logic [CW-1:0] r_since;     // cycles since the last E rise (saturating)
    logic [CW-1:0] r_wcnt;      // init wait counter
    logic [CW-1:0] r_pcnt;      // cycles spent in the current busy poll
    logic [2:0]    r_iidx;
    logic          r_p_rs, r_p_rw;
    logic [7:0]    r_p_data;
    logic [7:0]    r_sample;
    logic          r_e, r_rs, r_rw, r_oe;
    logic [7:0]    r_wd;
    logic          r_ready, r_rsp_valid, r_init_done, r_bto;
    logic [7:0]    r_rsp_data;

    logic          w_access, w_start, w_done, w_bus_act, w_poll_ok;
    logic          w_load_cmd, w_load_init;
    logic          w_acc_rs, w_acc_rw;
    logic [7:0]    w_acc_data, w_init_byte;

    always_comb begin
        w_access   = (r_st == ST_F1) || (r_st == ST_F2) || (r_st == ST_F3) ||
                     (r_st == ST_POLL) || (r_st == ST_EXEC);
        w_acc_rs   = 1'b0;
        w_acc_rw   = 1'b0;
        w_acc_data = 8'h38;
        if (r_st == ST_POLL) begin
            w_acc_rw = 1'b1;
        end else if (r_st == ST_EXEC) begin
            w_acc_rs   = r_p_rs;
            w_acc_rw   = r_p_rw;
            w_acc_data = r_p_data;
        end

        case (r_iidx)
            3'd0:    w_init_byte = 8'h38;
            3'd1:    w_init_byte = 8'h0C;
            3'd2:    w_init_byte = 8'h01;
            default: w_init_byte = 8'h06;
        endcase

        // Bus cycle engine: an access state with the engine idle means "go".
        w_start   = w_access && (r_ph == PH_IDLE);
        w_ph_nx   = r_ph;
        w_bcnt_nx = r_bcnt + c_one;
        w_done    = 1'b0;
        case (r_ph)
            PH_IDLE: begin
                w_bcnt_nx = '0;
                if (w_start) w_ph_nx = PH_SETUP;
            end
            PH_SETUP: if (r_bcnt == c_as_last) begin
                w_ph_nx   = PH_PULSE;
                w_bcnt_nx = '0;
            end
            PH_PULSE: if (r_bcnt == c_pw_last) begin
                w_ph_nx   = PH_HOLD;
                w_bcnt_nx = '0;
            end
            PH_HOLD: if (r_bcnt == c_h_last) begin
                w_ph_nx   = PH_RECOVER;
                w_bcnt_nx = '0;
            end
            PH_RECOVER: begin
                w_bcnt_nx = '0;
                if (r_since >= c_rec) begin
                    w_ph_nx = PH_IDLE;
                    w_done  = 1'b1;
                end
            end
            default: w_ph_nx = PH_IDLE;
        endcase
        w_bus_act = (w_ph_nx == PH_SETUP) || (w_ph_nx == PH_PULSE) ||
                    (w_ph_nx == PH_HOLD);

        // A timed-out poll lets the pending access run anyway.
        w_poll_ok   = !r_sample[7] || (r_pcnt == c_bto);
        w_st_nx     = r_st;
        w_load_cmd  = 1'b0;
        w_load_init = 1'b0;
        case (r_st)
            ST_PWR_WAIT:  if (r_wcnt == c_pwr_last)  w_st_nx = ST_F1;
            ST_F1:        if (w_done)                w_st_nx = ST_GAP1;
            ST_GAP1:      if (r_wcnt == c_gap1_last) w_st_nx = ST_F2;
            ST_F2:        if (w_done)                w_st_nx = ST_GAP2;
            ST_GAP2:      if (r_wcnt == c_gap2_last) w_st_nx = ST_F3;
            ST_F3:        if (w_done)                w_st_nx = ST_INIT_CMDS;
            ST_INIT_CMDS: begin
                if (r_iidx == 3'd4) begin
                    w_st_nx = ST_IDLE;
                end else begin
                    w_st_nx     = ST_POLL;
                    w_load_init = 1'b1;
                end
            end
            ST_IDLE: if (cmd_valid && r_ready) begin
                w_st_nx    = ST_POLL;
                w_load_cmd = 1'b1;
            end
            ST_POLL: if (w_done && w_poll_ok) w_st_nx = ST_EXEC;
            ST_EXEC: if (w_done) w_st_nx = r_init_done ? ST_IDLE : ST_INIT_CMDS;
            default: w_st_nx = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st        <= ST_PWR_WAIT;
            r_ph        <= PH_IDLE;
            r_bcnt      <= '0;
            r_since     <= c_cyc;
            r_wcnt      <= '0;
            r_pcnt      <= '0;
            r_iidx      <= 3'd0;
            r_p_rs      <= 1'b0;
            r_p_rw      <= 1'b0;
            r_p_data    <= 8'h00;
            r_sample    <= 8'h00;
            r_e         <= 1'b0;
            r_rs        <= 1'b0;
            r_rw        <= 1'b1;
            r_oe        <= 1'b0;
            r_wd        <= 8'h00;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_init_done <= 1'b0;
            r_bto       <= 1'b0;
        end else begin
            r_st   <= w_st_nx;
            r_ph   <= w_ph_nx;
            r_bcnt <= w_bcnt_nx;
            r_wcnt <= (w_st_nx != r_st) ? '0 : r_wcnt + c_one;

            if (w_ph_nx == PH_PULSE && r_ph != PH_PULSE) r_since <= c_one;
            else if (r_since != c_cyc)                    r_since <= r_since + c_one;

            if (r_st != ST_POLL)     r_pcnt <= '0;
            else if (r_pcnt != c_bto) r_pcnt <= r_pcnt + c_one;
            if (r_st == ST_POLL && r_pcnt == c_bto) r_bto <= 1'b1;

            if (w_load_cmd) begin
                r_p_rs   <= cmd_rs;
                r_p_rw   <= cmd_rw;
                r_p_data <= cmd_data;
            end else if (w_load_init) begin
                r_p_rs   <= 1'b0;
                r_p_rw   <= 1'b0;
                r_p_data <= w_init_byte;
                r_iidx   <= r_iidx + 3'd1;
            end

            if (r_ph == PH_PULSE && r_bcnt == c_pw_last) r_sample <= LCD_data;

            r_rsp_valid <= 1'b0;
            if (r_st == ST_EXEC && r_p_rw && r_ph == PH_HOLD && r_bcnt == c_h_last) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_sample;
            end

            // Bus pins follow the engine's next phase so they stay registered.
            r_e         <= (w_ph_nx == PH_PULSE);
            r_rs        <= w_bus_act ? w_acc_rs : 1'b0;
            r_rw        <= w_bus_act ? w_acc_rw : 1'b1;
            r_oe        <= w_bus_act && !w_acc_rw;
            r_wd        <= w_acc_data;
            r_ready     <= (w_st_nx == ST_IDLE);
            r_init_done <= r_init_done || (w_st_nx == ST_IDLE);
        end
    end

    assign LCD_data     = r_oe ? r_wd : 8'hzz;
    assign LCD_E        = r_e;
    assign LCD_RS       = r_rs;
    assign LCD_RW       = r_rw;
    assign cmd_ready    = r_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign init_done    = r_init_done;
    assign busy_timeout = r_bto;

endmodule
`default_nettype wire

// File: tb/tb_lcd_16207_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_16207_sequencer
// Description : Self-checking bench for lcd_16207_sequencer with a behavioural
//               LCD model. Expected bus accesses and read responses are queued
//               when stimulus is issued and compared as the bus produces them.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_16207_sequencer;

    localparam int T_AS = 2, T_PW = 3, T_H = 1, T_CYCLE = 10;
    localparam int POWERUP = 50, INIT_GAP = 20, INIT_GAP_SHORT = 5, BUSY_TIMEOUT = 40;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] d;
    } acc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, init_done, busy_timeout;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic [7:0] rsp_data;
    wire  [7:0] LCD_data;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    acc_t       sb_q[$];
    logic [7:0] rsp_q[$];
    int         rsp_cnt = 0;

    // LCD model controls
    logic [7:0] m_val = 8'h00;
    logic [7:0] read_val = 8'h00;
    int         busy_left = 0;
    bit         stuck = 1'b0;
    bit         tolerant = 1'b0;
    bit         in_init = 1'b0;
    int         rel_cyc = 0;

    assign LCD_data = (LCD_E && LCD_RW) ? m_val : 8'hzz;

    lcd_16207_sequencer #(
        .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_CYCLE(T_CYCLE),
        .POWERUP(POWERUP), .INIT_GAP(INIT_GAP), .INIT_GAP_SHORT(INIT_GAP_SHORT),
        .BUSY_TIMEOUT(BUSY_TIMEOUT), .CW(20)
    ) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rs(cmd_rs), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .init_done(init_done), .busy_timeout(busy_timeout),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_data(LCD_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_acc(input logic rs, input logic rw, input logic [7:0] d);
        acc_t a;
        a.rs = rs;
        a.rw = rw;
        a.d  = d;
        sb_q.push_back(a);
    endtask

    task automatic push_init();
        logic [7:0] ib [4];
        ib = '{8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 3; i++) push_acc(1'b0, 1'b0, 8'h38);
        for (int i = 0; i < 4; i++) begin
            push_acc(1'b0, 1'b1, 8'h00);
            push_acc(1'b0, 1'b0, ib[i]);
        end
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("init_done", 32'(init_done), 32'd1);
        chk("ready_with_init_done", 32'(cmd_ready), 32'd1);
        chk("init_seq_complete", 32'(sb_q.size()), 32'd0);
        in_init = 1'b0;
    endtask

    task automatic send_cmd(input logic rs, input logic rw, input logic [7:0] d);
        int n = 0;
        cmd_rs    = rs;
        cmd_rw    = rw;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("handshake", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(cmd_ready && sb_q.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Bus monitor, LCD model and scoreboard consumer.
    bit         prev_e = 1'b0;
    int         hcnt = 0;
    int         last_rise = -1;
    int         stab = 0;
    int         n_acc = 0;
    int         fall0 = 0;
    int         fall1 = 0;
    logic [9:0] prev_sig = '0;
    logic [9:0] rise_sig = '0;

    always @(negedge clk) begin
        logic [9:0] sig;
        acc_t       e;
        sig = {LCD_RS, LCD_RW, (LCD_RW ? 8'h00 : LCD_data)};
        if (reset) begin
            prev_e    = 1'b0;
            hcnt      = 0;
            last_rise = -1;
            n_acc     = 0;
            stab      = 0;
            prev_sig  = sig;
        end else begin
            stab     = (sig == prev_sig) ? stab + 1 : 1;
            prev_sig = sig;
            if (LCD_E && !prev_e) begin
                chk("setup_stable", 32'(stab >= T_AS + 1), 32'd1);
                if (last_rise >= 0) chk("e_spacing", 32'((cyc - last_rise) >= T_CYCLE), 32'd1);
                if (in_init) begin
                    if (n_acc == 0) chk("powerup_wait", 32'((cyc - rel_cyc) >= POWERUP), 32'd1);
                    if (n_acc == 1) chk("init_gap1", 32'((cyc - fall0) >= INIT_GAP), 32'd1);
                    if (n_acc == 2) chk("init_gap2", 32'((cyc - fall1) >= INIT_GAP_SHORT), 32'd1);
                end
                last_rise = cyc;
                hcnt      = 0;
                rise_sig  = sig;
                if (LCD_RW) begin
                    if (LCD_RS)              m_val = read_val;
                    else if (stuck)          m_val = 8'h80;
                    else if (busy_left > 0) begin
                        m_val = 8'h80;
                        busy_left--;
                    end else                 m_val = 8'h00;
                end
            end
            if (LCD_E) hcnt++;
            if (!LCD_E && prev_e) begin
                chk("e_width", 32'(hcnt), 32'(T_PW));
                chk("hold_stable", 32'(sig), 32'(rise_sig));
                if (n_acc == 0) fall0 = cyc;
                if (n_acc == 1) fall1 = cyc;
                n_acc++;
                if (tolerant && !LCD_RS && LCD_RW) begin
                    // unscored poll while D7 is stuck
                end else if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("acc_rs", 32'(LCD_RS), 32'(e.rs));
                    chk("acc_rw", 32'(LCD_RW), 32'(e.rw));
                    if (!e.rw) chk("acc_data", 32'(LCD_data), 32'(e.d));
                end
            end
            prev_e = LCD_E;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else                   chk("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        repeat (3) @(negedge clk);
        chk("rst_E", 32'(LCD_E), 32'd0);
        chk("rst_RS", 32'(LCD_RS), 32'd0);
        chk("rst_RW", 32'(LCD_RW), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy_timeout", 32'(busy_timeout), 32'd0);

        // Power-on init
        push_init();
        in_init = 1'b1;
        rel_cyc = cyc;
        reset   = 1'b0;
        wait_init();

        // Plain write: one poll, then the write
        push_acc(1'b0, 1'b1, 8'h00);
        push_acc(1'b1, 1'b0, 8'h41);
        send_cmd(1'b1, 1'b0, 8'h41);
        wait_done("write_done");
        chk("write_no_timeout", 32'(busy_timeout), 32'd0);

        // Busy for three polls: four polls then the write
        busy_left = 3;
        for (int i = 0; i < 4; i++) push_acc(1'b0, 1'b1, 8'h00);
        push_acc(1'b0, 1'b0, 8'h55);
        send_cmd(1'b0, 1'b0, 8'h55);
        wait_done("busy_write_done");
        chk("busy_no_timeout", 32'(busy_timeout), 32'd0);

        // Read with response
        read_val = 8'h5A;
        c0 = rsp_cnt;
        push_acc(1'b0, 1'b1, 8'h00);
        push_acc(1'b1, 1'b1, 8'h00);
        rsp_q.push_back(8'h5A);
        send_cmd(1'b1, 1'b1, 8'h00);
        wait_done("read_done");
        chk("rsp_pulse_count", 32'(rsp_cnt - c0), 32'd1);
        chk("rsp_data_held", 32'(rsp_data), 32'h5A);

        // Busy flag stuck: timeout flag, write still performed
        stuck    = 1'b1;
        tolerant = 1'b1;
        push_acc(1'b1, 1'b0, 8'h33);
        send_cmd(1'b1, 1'b0, 8'h33);
        n = 0;
        while (!busy_timeout && n < BUSY_TIMEOUT + T_CYCLE) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_flag", 32'(busy_timeout), 32'd1);
        wait_done("timeout_write_done");
        stuck    = 1'b0;
        tolerant = 1'b0;
        push_acc(1'b0, 1'b1, 8'h00);
        push_acc(1'b0, 1'b0, 8'h02);
        send_cmd(1'b0, 1'b0, 8'h02);
        wait_done("after_timeout_done");
        chk("timeout_sticky", 32'(busy_timeout), 32'd1);

        // Reset while E is high
        push_acc(1'b0, 1'b1, 8'h00);
        push_acc(1'b1, 1'b0, 8'h77);
        send_cmd(1'b1, 1'b0, 8'h77);
        n = 0;
        while (!LCD_E && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("e_seen_before_reset", 32'(LCD_E), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_E", 32'(LCD_E), 32'd0);
        chk("abort_RW", 32'(LCD_RW), 32'd1);
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        chk("abort_init_done", 32'(init_done), 32'd0);
        chk("abort_busy_timeout", 32'(busy_timeout), 32'd0);
        sb_q.delete();
        rsp_q.delete();
        @(negedge clk);
        push_init();
        in_init = 1'b1;
        rel_cyc = cyc;
        reset   = 1'b0;
        wait_init();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
